// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit that sequences
// the 8-bit datapath through FETCH/DECODE/EXECUTE/MEM/WB.
package ctrl_pkg;

    localparam int CTRL_IW = 17;
    localparam int CTRL_DW = 8;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXECUTE  = 4'd3,
        S_ALUWB    = 4'd4,
        S_MEMADDR  = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWB    = 4'd7,
        S_MEMWRITE = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_MI = 3'b011;
    localparam logic [2:0] COND_PL = 3'b100;
    localparam logic [2:0] COND_CS = 3'b101;
    localparam logic [2:0] COND_CC = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_ONE = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DROUT  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] FUNCT_ADD = 3'b000;
    localparam logic [2:0] FUNCT_SUB = 3'b001;
    localparam logic [2:0] FUNCT_CMP = 3'b111;

endpackage

// File: rtl/cond_unit.sv
// Branch condition evaluation: maps a 3-bit condition code and the live
// datapath flags to a single pass/fail bit.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       flag_c,
    output logic       cond_pass
);

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_AL: cond_pass = 1'b1;
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = ~flag_c;
            COND_NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: latches the instruction in FETCH, decodes register
// addresses from the IR and drives Moore-style datapath strobes per state.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int IW = CTRL_IW,
    parameter int DW = CTRL_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [IW-1:0] instr_in,
    input  logic          flag_z,
    input  logic          flag_n,
    input  logic          flag_c,
    output logic          PCWrite,
    output logic          MemWrite,
    output logic          RegWrite,
    output logic          ALUSrcA,
    output logic          mode,
    output logic [1:0]    ALUSrcB,
    output logic [1:0]    ResultSrc,
    output logic [2:0]    ALU_control,
    output logic [2:0]    A1,
    output logic [2:0]    A2,
    output logic [2:0]    A3,
    output logic [DW-1:0] imm,
    output logic          instr_done,
    output logic          illegal,
    output logic [3:0]    dbg_state
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    state_t        after_done;
    logic          cond_pass;

    logic [1:0] op;
    logic [2:0] funct;
    logic       i_bit;
    logic       l_bit;
    logic [2:0] dp_rd, dp_rn, dp_rm;
    logic [2:0] mem_rd, mem_rn;
    logic [2:0] br_cond;

    assign op      = ir_q[16:15];
    assign funct   = ir_q[14:12];
    assign dp_rd   = ir_q[11:9];
    assign i_bit   = ir_q[8];
    assign dp_rn   = ir_q[7:5];
    assign dp_rm   = ir_q[4:2];
    assign l_bit   = ir_q[14];
    assign mem_rd  = ir_q[13:11];
    assign mem_rn  = ir_q[10:8];
    assign br_cond = ir_q[14:12];

    assign dbg_state = state_q;

    cond_unit u_cond (
        .cond      (br_cond),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .cond_pass (cond_pass)
    );

    // Reset clears state and IR together, so every Moore output drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        after_done = run ? S_FETCH : S_IDLE;
        case (state_q)
            S_IDLE:    if (run) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = instr_in;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_DP:   state_d = S_EXECUTE;
                    OP_MEM:  state_d = S_MEMADDR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = after_done;
                endcase
            end
            S_EXECUTE: state_d = (funct == FUNCT_CMP) ? after_done : S_ALUWB;
            S_MEMADDR: state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_ALUWB, S_MEMWB, S_MEMWRITE, S_BRANCH: state_d = after_done;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        mode        = 1'b0;
        ALUSrcB     = SRCB_RD2;
        ResultSrc   = RES_ALUOUT;
        ALU_control = FUNCT_ADD;
        A1          = 3'd0;
        A2          = 3'd0;
        A3          = 3'd0;
        imm         = '0;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        // Addresses and imm are live in every non-IDLE state, including
        // FETCH where they still reflect the previous instruction.
        if (state_q != S_IDLE) begin
            imm = ir_q[DW-1:0];
            case (op)
                OP_DP: begin
                    A1 = i_bit ? dp_rd : dp_rn;
                    A2 = i_bit ? 3'd0 : dp_rm;
                    A3 = dp_rd;
                end
                OP_MEM: begin
                    A1 = mem_rn;
                    A2 = l_bit ? 3'd0 : mem_rd;
                    A3 = l_bit ? mem_rd : 3'd0;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_ONE;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_ONE;
                ResultSrc = RES_ALU;
                if (op == OP_RSV) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_EXECUTE: begin
                ALUSrcB     = i_bit ? SRCB_IMM : SRCB_RD2;
                ALU_control = funct;
                mode        = (funct == FUNCT_CMP);
                instr_done  = (funct == FUNCT_CMP);
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMADDR:  ALUSrcB = SRCB_IMM;
            S_MEMWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = RES_DROUT;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                PCWrite    = cond_pass;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALU;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: an instruction-level model
// predicts every cycle's outputs, plus literal checks at key cycles.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       srca;
        logic       mode;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [2:0] aluc;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [2:0] a3;
        logic [7:0] imm;
        logic       done;
        logic       ill;
    } out_t;

    localparam int W = $bits(out_t);

    typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXECUTE, P_ALUWB, P_MEMADDR,
                  P_MEMREAD, P_MEMWB, P_MEMWRITE, P_BRANCH} step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [16:0] instr_in;
    logic        flag_z, flag_n, flag_c;
    logic        PCWrite, MemWrite, RegWrite, ALUSrcA, mode;
    logic [1:0]  ALUSrcB, ResultSrc;
    logic [2:0]  ALU_control, A1, A2, A3;
    logic [7:0]  imm;
    logic        instr_done, illegal;
    logic [3:0]  dbg_state;
    out_t        dut_o;

    logic [W-1:0] exp_q[$];
    logic [16:0]  m_ir;
    int           last_len;
    int           checks = 0;
    int           errors = 0;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .run(run), .instr_in(instr_in),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .mode(mode), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALU_control(ALU_control),
        .A1(A1), .A2(A2), .A3(A3), .imm(imm),
        .instr_done(instr_done), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign dut_o = {PCWrite, MemWrite, RegWrite, ALUSrcA, mode, ALUSrcB, ResultSrc,
                    ALU_control, A1, A2, A3, imm, instr_done, illegal};

    // Expected outputs for one step of an instruction whose word is ir.
    function automatic out_t model_out(input step_t s, input logic [16:0] ir,
                                       input logic z, input logic n, input logic c);
        out_t       o;
        logic [7:0] pass_tbl;
        o = '0;
        pass_tbl = {1'b0, ~c, c, ~n, n, ~z, z, 1'b1};
        if (s == P_IDLE) return o;
        o.imm = ir[7:0];
        if (ir[16:15] == 2'b00) begin
            o.a3 = ir[11:9];
            if (ir[8]) o.a1 = ir[11:9];
            else begin
                o.a1 = ir[7:5];
                o.a2 = ir[4:2];
            end
        end else if (ir[16:15] == 2'b01) begin
            o.a1 = ir[10:8];
            if (ir[14]) o.a3 = ir[13:11];
            else        o.a2 = ir[13:11];
        end
        case (s)
            P_FETCH:   begin o.pcw = 1; o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; end
            P_DECODE: begin
                o.srca = 1; o.srcb = 2'b10; o.res = 2'b10;
                if (ir[16:15] == 2'b11) begin o.ill = 1; o.done = 1; end
            end
            P_EXECUTE: begin
                o.srcb = ir[8] ? 2'b01 : 2'b00;
                o.aluc = ir[14:12];
                o.mode = (ir[14:12] == 3'b111);
                o.done = (ir[14:12] == 3'b111);
            end
            P_ALUWB:    begin o.regw = 1; o.done = 1; end
            P_MEMADDR:  o.srcb = 2'b01;
            P_MEMWB:    begin o.regw = 1; o.res = 2'b01; o.done = 1; end
            P_MEMWRITE: begin o.memw = 1; o.done = 1; end
            P_BRANCH: begin
                o.pcw = pass_tbl[ir[14:12]];
                o.srca = 1; o.srcb = 2'b01; o.res = 2'b10; o.done = 1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Compare process: one expected entry per cycle while the queue is non-empty.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (dut_o !== out_t'(e)) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, dut_o, e);
            end
            checks++;
            if ((32'(PCWrite) + 32'(MemWrite) + 32'(RegWrite)) > 1) begin
                errors++;
                $display("FAIL one_write_strobe t=%0t actual=%b%b%b expected at most one set",
                         $time, PCWrite, MemWrite, RegWrite);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drive one instruction (entering FETCH at the next edge) and queue its cycles.
    task automatic start_instr(input logic [16:0] w, input logic z, input logic n, input logic c);
        step_t seq[$];
        run = 1'b1; instr_in = w; flag_z = z; flag_n = n; flag_c = c;
        seq.push_back(P_FETCH);
        seq.push_back(P_DECODE);
        case (w[16:15])
            2'b00: begin
                seq.push_back(P_EXECUTE);
                if (w[14:12] != 3'b111) seq.push_back(P_ALUWB);
            end
            2'b01: begin
                seq.push_back(P_MEMADDR);
                if (w[14]) begin seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
                else seq.push_back(P_MEMWRITE);
            end
            2'b10: seq.push_back(P_BRANCH);
            default: ;
        endcase
        foreach (seq[i]) begin
            if (i == 1) m_ir = w;
            exp_q.push_back(model_out(seq[i], m_ir, z, n, c));
        end
        last_len = seq.size();
    endtask

    task automatic run_instr(input logic [16:0] w, input logic [2:0] znc);
        start_instr(w, znc[2], znc[1], znc[0]);
        step(last_len);
    endtask

    task automatic idle_cycles(input int n);
        run = 1'b0;
        repeat (n) exp_q.push_back('0);
        step(n);
    endtask

    localparam logic [16:0] W_ADD = 17'b00000010000101100;
    localparam logic [16:0] W_LDR = 17'b01101000100000101;
    localparam logic [16:0] W_STR = 17'b01001100100000010;
    localparam logic [16:0] W_BEQ = 17'b10001000011111110;
    localparam logic [16:0] W_RSV = 17'b11000000010101010;
    localparam logic [16:0] W_CMPI = 17'b00_111_100_1_00000011;

    localparam int NT = 11;
    localparam logic [16:0] TW [NT] = '{
        17'b00_001_101_1_01111111,   // SUB r5, #0x7F
        17'b00_111_000_0_010_011_00, // CMP r2, r3
        17'b00_011_111_0_110_101_00, // funct 011 r7 = r6 op r5
        17'b10_010_0000_00000100,    // BNE, Z=0 taken
        17'b10_011_0000_11110000,    // BMI, N=1 taken
        17'b10_100_0000_00010001,    // BPL, N=1 not taken
        17'b10_101_0000_00100010,    // BCS, C=1 taken
        17'b10_110_0000_00110011,    // BCC, C=1 not taken
        17'b10_111_0000_01000100,    // never, all flags set
        17'b10_000_0000_01010101,    // always
        17'b01_1_111_000_10000000    // LDR r7, [r0, #0x80]
    };
    localparam logic [2:0] TF [NT] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                                       3'b010, 3'b001, 3'b001, 3'b111, 3'b000, 3'b000};

    initial begin
        reset = 1'b1; run = 1'b0; instr_in = '0;
        flag_z = 1'b0; flag_n = 1'b0; flag_c = 1'b0;
        m_ir = '0;
        step(1);
        lit("reset_outputs", 32'(dut_o), 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // ADD r2 = r1 + r3
        start_instr(W_ADD, 0, 0, 0);
        step(1); lit("add_fetch_pcwrite", 32'(PCWrite), 32'd1);
        step(2);
        lit("add_exec_aluctl", 32'(ALU_control), 32'd0);
        lit("add_exec_srcb", 32'(ALUSrcB), 32'd0);
        lit("add_exec_a1", 32'(A1), 32'd1);
        lit("add_exec_a2", 32'(A2), 32'd3);
        step(1);
        lit("add_wb_regwrite", 32'(RegWrite), 32'd1);
        lit("add_wb_ressrc", 32'(ResultSrc), 32'd0);
        lit("add_wb_a3", 32'(A3), 32'd2);
        lit("add_wb_done", 32'(instr_done), 32'd1);

        // LDR r2, [r1, #5]; run drops mid-instruction and must be ignored
        start_instr(W_LDR, 0, 0, 0);
        step(1); run = 1'b0;
        step(2);
        lit("ldr_addr_a1", 32'(A1), 32'd1);
        lit("ldr_addr_imm", 32'(imm), 32'd5);
        lit("ldr_addr_srcb", 32'(ALUSrcB), 32'd1);
        step(2);
        lit("ldr_wb_regwrite", 32'(RegWrite), 32'd1);
        lit("ldr_wb_ressrc", 32'(ResultSrc), 32'd1);
        lit("ldr_wb_a3", 32'(A3), 32'd2);
        idle_cycles(1);

        // STR r3, [r1, #2]
        start_instr(W_STR, 0, 0, 0);
        step(4);
        lit("str_memwrite", 32'(MemWrite), 32'd1);
        lit("str_a1", 32'(A1), 32'd1);
        lit("str_a2", 32'(A2), 32'd3);

        // BEQ -2, not taken then taken
        start_instr(W_BEQ, 0, 0, 0);
        step(3); lit("beq_nt_pcwrite", 32'(PCWrite), 32'd0);
        start_instr(W_BEQ, 1, 0, 0);
        step(3);
        lit("beq_t_pcwrite", 32'(PCWrite), 32'd1);
        lit("beq_t_srca", 32'(ALUSrcA), 32'd1);
        lit("beq_t_srcb", 32'(ALUSrcB), 32'd1);
        lit("beq_t_imm", 32'(imm), 32'hFE);

        // CMP with immediate finishes in EXECUTE
        start_instr(W_CMPI, 0, 0, 0);
        step(3);
        lit("cmp_mode", 32'(mode), 32'd1);
        lit("cmp_done", 32'(instr_done), 32'd1);
        lit("cmp_aluctl", 32'(ALU_control), 32'd7);
        lit("cmp_a1", 32'(A1), 32'd4);

        for (int i = 0; i < NT; i++) run_instr(TW[i], TF[i]);

        // Reserved opcode, then straight into FETCH of the next instruction
        start_instr(W_RSV, 0, 0, 0);
        step(2);
        lit("rsv_illegal", 32'(illegal), 32'd1);
        lit("rsv_done", 32'(instr_done), 32'd1);
        start_instr(W_ADD, 0, 0, 0);
        step(1); lit("rsv_next_fetch", 32'(PCWrite), 32'd1);
        step(3);

        // Reset asserted in the middle of MEMWRITE
        start_instr(W_STR, 0, 0, 0);
        step(4);
        lit("rst_pre_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        lit("rst_memwrite_drop", 32'(MemWrite), 32'd0);
        lit("rst_outputs_zero", 32'(dut_o), 32'd0);
        m_ir = '0;
        step(1);
        reset = 1'b0;
        idle_cycles(3);
        lit("post_rst_idle", 32'(dut_o), 32'd0);

        lit("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle control FSM that drives the control inputs of the 8-bit datapath (veri_datapath).
- Latches the 17-bit instruction into an internal instruction register (IR) during FETCH.
- Decodes register addresses and the immediate from the IR.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB for data-processing, LDR/STR and branch instructions, replacing hand-driven control strobes.

Parameters:
- IW, 17, instruction width (fixed ISA; other values unsupported)
- DW, 8, datapath/immediate width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  permits leaving IDLE / starting the next instruction
- instr_in  in  17  instruction word from instruction memory, sampled in FETCH
- flag_z  in  1  datapath zero flag
- flag_n  in  1  datapath negative flag
- flag_c  in  1  datapath carry flag
- PCWrite, MemWrite, RegWrite, ALUSrcA, mode  out  1 each  datapath strobes/selects
- ALUSrcB  out  2  00 RD2, 01 imm, 10 constant 1
- ResultSrc  out  2  00 ALU_out reg, 01 DR_out, 10 ALU result
- ALU_control  out  3  ALU operation
- A1, A2, A3  out  3 each  register file addresses
- imm  out  8  IR[7:0]
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  one-cycle pulse in DECODE on op=11

Behaviour:
- Encoding; op = IR[16:15]:
  - DP (00): funct IR[14:12], rd IR[11:9], I IR[8]. If I=1, imm IR[7:0]. If I=0, rn IR[7:5], rm IR[4:2].
  - MEM (01): L IR[14] (1=LDR), rd IR[13:11], rn IR[10:8], imm IR[7:0].
  - BR (10): cond IR[14:12], imm IR[7:0] (signed offset, applied by the datapath).
  - op=11 is reserved.
- Address decode (combinational from IR):
  - DP: A1 = I ? rd : rn; A2 = rm; A3 = rd.
  - STR: A1 = rn; A2 = rd.
  - LDR: A1 = rn; A3 = rd.
  - Unused addresses = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, ALUWB, MEMADDR, MEMREAD, MEMWB, MEMWRITE, BRANCH.
- Outputs are Moore, decoded from state and IR. Any strobe not listed in a state is 0.
- IDLE: all outputs 0. Go to FETCH if run, else stay.
- FETCH: PCWrite=1, ALUSrcA=1, ALUSrcB=10, ALU_control=000, ResultSrc=10. IR <= instr_in. Go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, no writes. Next state:
  - DP → EXECUTE
  - MEM → MEMADDR
  - BR → BRANCH
  - op=11 → pulse illegal and instr_done, then go to FETCH if run, else IDLE.
- EXECUTE: ALUSrcA=0, ALUSrcB = I ? 01 : 00, ALU_control = funct.
  - mode = 1 only when funct=111 (CMP: flag update).
  - CMP: pulse instr_done, skip ALUWB.
  - Otherwise go to ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00, instr_done.
- MEMADDR: ALUSrcA=0, ALUSrcB=01, ALU_control=000. Go to MEMREAD if L, else MEMWRITE.
- MEMWRITE: MemWrite=1, instr_done.
- MEMREAD: ResultSrc=00; memory read; no strobes. Go to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, instr_done.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ALU_control=000, ResultSrc=10, instr_done. PCWrite = cond_pass.
- cond_pass by cond:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 N
  - 100 !N
  - 101 C
  - 110 !C
  - 111 never
- Flags are sampled combinationally in BRANCH.
- Instruction latency (FETCH to done, inclusive): DP 4, CMP 3, STR 4, LDR 5, BR 3, reserved 2.
- After any instr_done state: go to FETCH if run, else IDLE. run is ignored mid-instruction; an instruction always completes.
- Reset (async, any state, including mid-MEMWRITE or mid-ALUWB):
  - state = IDLE, IR = 0.
  - All outputs 0 immediately, without waiting for a clock edge.
  - No partial write strobe survives reset assertion.
- At most one of PCWrite/MemWrite/RegWrite is asserted in any cycle.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - op codes (OP_DP, OP_MEM, OP_BR, OP_RSV)
  - cond codes
  - ALUSrcB/ResultSrc encodings
  - FUNCT_ADD=000, FUNCT_SUB=001, FUNCT_CMP=111
- One combinational sub-module: cond_unit (cond, flag_z/n/c → cond_pass).

Test Plan:
- Reset held, then run=1, instr_in=17'b00000010000101100 (ADD r2=r1+r3):
  - cycle 1: FETCH with PCWrite=1.
  - cycle 3: EXECUTE with ALU_control=000, ALUSrcB=00, A1=1, A2=3.
  - cycle 4: RegWrite=1, ResultSrc=00, A3=2, instr_done.
- instr_in=17'b01101000100000101 (LDR r2,[r1,#5]):
  - MEMADDR: A1=1, imm=5, ALUSrcB=01.
  - cycle 5: RegWrite=1, ResultSrc=01, A3=2.
  - MemWrite stays 0 throughout.
- instr_in=17'b01001100100000010 (STR r3,[r1,#2]):
  - cycle 4: MemWrite=1 for exactly one cycle, A1=1, A2=3.
  - RegWrite stays 0.
- instr_in=17'b10001000011111110 (BEQ -2):
  - flag_z=0 → PCWrite only in FETCH.
  - flag_z=1 → PCWrite=1 in cycle 3 with ALUSrcA=1, ALUSrcB=01, imm=8'hFE.
- Assert reset during MEMWRITE → MemWrite=0 before the next clock edge. After release with run=0: stays IDLE, all outputs 0.
- op=11 word with run=1 → illegal and instr_done pulse in DECODE; the next cycle is FETCH.
